fetch_unit: RTL and testbench
=============================

// Module: fetch_unit
//
// PURPOSE
//  Instruction-fetch stage between the PC and the decode stage. It owns the PC
//  register and drives the word address into the instruction ROM (64 x 32,
//  combinational read). Fetched words go into a small FIFO, which presents
//  {instr, pc, pc+4} to decode through a valid/ready handshake.
//  Branch, jal and jalr redirects flush the FIFO and reload the PC.
//
// PARAMETERS
//  RESET_PC    32'h0000_0000  PC value loaded on reset
//  FIFO_DEPTH  2              fetch-queue entries; power of 2, >= 2
//  IMEM_WORDS  64             ROM size in words; fetch PC >= IMEM_WORDS*4 is out of bounds
//
// PORTS
//  clk             in   1   clock, rising edge
//  reset           in   1   asynchronous, active-high reset
//  imem_addr       out  32  byte address to ROM; equals fetch_pc
//  imem_rdata      in   32  ROM word at imem_addr, valid in the same cycle
//  redirect_valid  in   1   decode/execute requests a PC change this cycle
//  redirect_pc     in   32  target byte address of the redirect
//  instr_valid     out  1   FIFO head is valid
//  instr_ready     in   1   decode accepts the FIFO head
//  instr           out  32  instruction word at the FIFO head
//  instr_pc        out  32  PC of the FIFO-head instruction
//  instr_pcplus4   out  32  instr_pc + 4, mod 2^32
//  misalign_err    out  1   sticky: a redirect target had [1:0] != 0
//  fetch_oob       out  1   high while fetch is halted in the OOB state
//
// BEHAVIOUR
//  Reset (asynchronous, takes effect immediately, including mid-operation):
//   fetch_pc=RESET_PC; FIFO count=0 and pointers=0; state=RUN;
//   instr_valid=0; misalign_err=0; fetch_oob=0; instr/instr_pc outputs=0.
//  FSM, two states:
//   RUN: fetching. If fetch_pc[31:2] >= IMEM_WORDS with no redirect, go to
//   OOB and do not push.
//   OOB: no push, fetch_pc held, fetch_oob=1. A redirect returns the FSM to RUN.
//  pop  = instr_valid & instr_ready.
//  push = (state==RUN) & in-bounds & ~redirect_valid & (count<FIFO_DEPTH | pop).
//   Push writes {imem_rdata, fetch_pc} and does fetch_pc <= fetch_pc+4 (wraps to 0).
//   Pushing while full is allowed only when a pop occurs in the same cycle;
//   the count is then unchanged, giving 1 instr/cycle throughput.
//  Redirect has priority over push and pop. At the edge:
//   - count=0; the flushed head is not considered consumed.
//   - fetch_pc <= {redirect_pc[31:2],2'b00}; state <= RUN.
//   - If redirect_pc[1:0] != 0, misalign_err <= 1 (sticky until reset).
//  instr_valid = (count != 0). Head outputs come from FIFO storage (registered).
//  Latency: the word at fetch_pc appears on instr one edge after it is pushed.
//   After reset release, edge 1 gives instr_valid=1 with PC=RESET_PC.
//  Empty: instr_valid=0 and head outputs hold their last values; decode ignores them.
//  Full with instr_ready=0: fetch_pc holds and no entry is dropped or overwritten.
//  Pointers wrap modulo FIFO_DEPTH; count is $clog2(FIFO_DEPTH)+1 bits wide.
//  instr_ready may be high while instr_valid=0; this has no effect.
//
// TESTING
//  1 Release reset, instr_ready=1: edge1 instr=0x00500113 pc=0x0; edge2 0x00C00193
//    pc=0x4; then one instr per cycle.
//  2 instr_ready=0 for 4 cycles after reset: count saturates at 2 and imem_addr
//    holds 0x8. On ready=1, pcs 0x0, 0x4, 0x8 delivered in order with no gap.
//  3 FIFO full, redirect_pc=0x28 with instr_ready=1: next valid instr=0x0023A233
//    pc=0x28, pcplus4=0x2C; flushed pcs 0x0/0x4 never appear after the redirect.
//  4 redirect_pc=0x2A: misalign_err=1 after the edge; fetch resumes at 0x28;
//    the flag stays 1 across later redirects.
//  5 redirect_pc=0xFC: 0xFC is delivered, then fetch_oob=1, instr_valid drops
//    after the drain, imem_addr holds 0x100; redirect to 0x0 clears fetch_oob.
//  6 Assert reset between clock edges while count=2: instr_valid=0 with no clock
//    edge; after release, edge1 delivers pc=0x0 again.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, reads the instruction ROM and queues
// {instr, pc} for decode behind a valid/ready handshake. Redirects flush and reload.
module fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned FIFO_DEPTH = 2,
  parameter int unsigned IMEM_WORDS = 64
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic [31:0] instr_pcplus4,
  output logic        misalign_err,
  output logic        fetch_oob
);

  localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(FIFO_DEPTH);
  localparam logic [29:0]      IMEM_LIM = 30'(IMEM_WORDS);

  typedef enum logic [0:0] {
    ST_RUN = 1'b0,
    ST_OOB = 1'b1
  } state_t;

  state_t           r_state;
  logic [31:0]      r_fetch_pc;
  logic [CNT_W-1:0] r_count;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W-1:0] r_wr_ptr;
  logic [31:0]      r_mem_instr [FIFO_DEPTH];
  logic [31:0]      r_mem_pc    [FIFO_DEPTH];
  logic [31:0]      r_instr;
  logic [31:0]      r_instr_pc;
  logic [31:0]      r_instr_pcplus4;
  logic             r_misalign;

  logic             w_inb;
  logic             w_pop;
  logic             w_push;
  logic             w_head_is_new;
  logic [PTR_W-1:0] w_next_rd;
  logic [CNT_W-1:0] w_next_count;

  // Handshake, push qualification and next-head selection.
  always_comb begin
    w_inb         = (r_fetch_pc[31:2] < IMEM_LIM);
    w_pop         = (r_count != {CNT_W{1'b0}}) & instr_ready;
    w_push        = (r_state == ST_RUN) & w_inb & ~redirect_valid &
                    ((r_count < DEPTH_C) | w_pop);
    w_next_rd     = w_pop ? (r_rd_ptr + PTR_W'(1'b1)) : r_rd_ptr;
    w_next_count  = r_count + CNT_W'(w_push) - CNT_W'(w_pop);
    // The entry being written this edge becomes the head when it lands at the new read slot.
    w_head_is_new = w_push & (w_next_rd == r_wr_ptr);
  end

  // Queue storage; contents are only visible through the head registers.
  always_ff @(posedge clk) begin
    if (!reset && w_push) begin
      r_mem_instr[r_wr_ptr] <= imem_rdata;
      r_mem_pc[r_wr_ptr]    <= r_fetch_pc;
    end
  end

  // PC, FSM, queue pointers, sticky flag and registered head outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state         <= ST_RUN;
      r_fetch_pc      <= RESET_PC;
      r_count         <= {CNT_W{1'b0}};
      r_rd_ptr        <= {PTR_W{1'b0}};
      r_wr_ptr        <= {PTR_W{1'b0}};
      r_instr         <= 32'h0000_0000;
      r_instr_pc      <= 32'h0000_0000;
      r_instr_pcplus4 <= 32'h0000_0004;
      r_misalign      <= 1'b0;
    end else if (redirect_valid) begin
      r_state    <= ST_RUN;
      r_fetch_pc <= {redirect_pc[31:2], 2'b00};
      r_count    <= {CNT_W{1'b0}};
      r_rd_ptr   <= {PTR_W{1'b0}};
      r_wr_ptr   <= {PTR_W{1'b0}};
      if (redirect_pc[1:0] != 2'b00) begin
        r_misalign <= 1'b1;
      end
    end else begin
      if (w_push) begin
        r_fetch_pc <= r_fetch_pc + 32'd4;
        r_wr_ptr   <= r_wr_ptr + PTR_W'(1'b1);
      end
      r_rd_ptr <= w_next_rd;
      r_count  <= w_next_count;
      if ((r_state == ST_RUN) && !w_inb) begin
        r_state <= ST_OOB;
      end
      // Head holds its last value when the queue goes empty.
      if (w_next_count != {CNT_W{1'b0}}) begin
        if (w_head_is_new) begin
          r_instr         <= imem_rdata;
          r_instr_pc      <= r_fetch_pc;
          r_instr_pcplus4 <= r_fetch_pc + 32'd4;
        end else begin
          r_instr         <= r_mem_instr[w_next_rd];
          r_instr_pc      <= r_mem_pc[w_next_rd];
          r_instr_pcplus4 <= r_mem_pc[w_next_rd] + 32'd4;
        end
      end
    end
  end

  assign imem_addr     = r_fetch_pc;
  assign instr_valid   = (r_count != {CNT_W{1'b0}});
  assign instr         = r_instr;
  assign instr_pc      = r_instr_pc;
  assign instr_pcplus4 = r_instr_pcplus4;
  assign misalign_err  = r_misalign;
  assign fetch_oob     = (r_state == ST_OOB);

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios plus randomized traffic, all checked
// against a queue-based reference model of the fetch stage.
module tb_fetch_unit;

  localparam int DEPTH = 2;

  logic        clk;
  logic        reset;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic [31:0] instr_pcplus4;
  logic        misalign_err;
  logic        fetch_oob;

  logic [31:0] rom [64];

  int checks;
  int failures;

  logic [31:0] q_instr [$];
  logic [31:0] q_pc    [$];
  logic [31:0] m_fpc;
  bit          m_oob;
  bit          m_mis;

  fetch_unit dut (
    .clk            (clk),
    .reset          (reset),
    .imem_addr      (imem_addr),
    .imem_rdata     (imem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .instr          (instr),
    .instr_pc       (instr_pc),
    .instr_pcplus4  (instr_pcplus4),
    .misalign_err   (misalign_err),
    .fetch_oob      (fetch_oob)
  );

  assign imem_rdata = (imem_addr < 32'h0000_0100) ? rom[imem_addr[7:2]] : 32'h0000_0013;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic check_model();
    check("valid", 32'(instr_valid), 32'(q_pc.size() != 0));
    check("imem_addr", imem_addr, m_fpc);
    check("fetch_oob", 32'(fetch_oob), 32'(m_oob));
    check("misalign", 32'(misalign_err), 32'(m_mis));
    if (q_pc.size() != 0) begin
      check("instr", instr, q_instr[0]);
      check("instr_pc", instr_pc, q_pc[0]);
      check("pcplus4", instr_pcplus4, q_pc[0] + 32'd4);
    end
  endtask

  task automatic model_reset();
    q_instr.delete();
    q_pc.delete();
    m_fpc = 32'h0000_0000;
    m_oob = 1'b0;
    m_mis = 1'b0;
  endtask

  // Drives one cycle, advances the model past the edge and compares.
  task automatic step(input bit rdy, input bit rv, input logic [31:0] rpc);
    bit pop;
    instr_ready    = rdy;
    redirect_valid = rv;
    redirect_pc    = rpc;
    pop = (q_pc.size() != 0) && rdy;
    @(posedge clk);
    if (rv) begin
      q_instr.delete();
      q_pc.delete();
      m_fpc = {rpc[31:2], 2'b00};
      m_oob = 1'b0;
      if (rpc[1:0] != 2'b00) m_mis = 1'b1;
    end else begin
      if (pop) begin
        void'(q_instr.pop_front());
        void'(q_pc.pop_front());
      end
      if (!m_oob) begin
        if (m_fpc >= 32'h0000_0100) begin
          m_oob = 1'b1;
        end else if (q_pc.size() < DEPTH) begin
          q_instr.push_back(rom[m_fpc[7:2]]);
          q_pc.push_back(m_fpc);
          m_fpc = m_fpc + 32'd4;
        end
      end
    end
    #1;
    check_model();
  endtask

  task automatic do_reset();
    reset          = 1'b1;
    instr_ready    = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    model_reset();
    #2;
    check("rst_valid", 32'(instr_valid), 32'h0);
    check("rst_addr", imem_addr, 32'h0);
    check("rst_instr", instr, 32'h0);
    check("rst_pc", instr_pc, 32'h0);
    check("rst_oob", 32'(fetch_oob), 32'h0);
    check("rst_mis", 32'(misalign_err), 32'h0);
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    logic [31:0] rpc;
    checks         = 0;
    failures       = 0;
    reset          = 1'b1;
    instr_ready    = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    for (int i = 0; i < 64; i++) rom[i] = $urandom;
    rom[0]  = 32'h0050_0113;
    rom[1]  = 32'h00C0_0193;
    rom[10] = 32'h0023_A233;
    #12;

    // Basic streaming after reset.
    do_reset();
    step(1'b1, 1'b0, 32'h0);
    check("t1_instr0", instr, 32'h0050_0113);
    check("t1_pc0", instr_pc, 32'h0);
    step(1'b1, 1'b0, 32'h0);
    check("t1_instr1", instr, 32'h00C0_0193);
    check("t1_pc1", instr_pc, 32'h4);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 32'h0);

    // Back-pressure saturates the queue, then drains with no gap.
    do_reset();
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 32'h0);
    check("t2_hold_addr", imem_addr, 32'h8);
    check("t2_head0", instr_pc, 32'h0);
    step(1'b1, 1'b0, 32'h0);
    check("t2_head1", instr_pc, 32'h4);
    step(1'b1, 1'b0, 32'h0);
    check("t2_head2", instr_pc, 32'h8);
    check("t2_valid", 32'(instr_valid), 32'h1);

    // Redirect flushes a full queue.
    do_reset();
    step(1'b0, 1'b0, 32'h0);
    step(1'b0, 1'b0, 32'h0);
    step(1'b1, 1'b1, 32'h28);
    check("t3_flush", 32'(instr_valid), 32'h0);
    step(1'b1, 1'b0, 32'h0);
    check("t3_instr", instr, 32'h0023_A233);
    check("t3_pc", instr_pc, 32'h28);
    check("t3_pcp4", instr_pcplus4, 32'h2C);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 32'h0);

    // Misaligned target sets the sticky flag.
    step(1'b1, 1'b1, 32'h2A);
    check("t4_mis", 32'(misalign_err), 32'h1);
    step(1'b1, 1'b0, 32'h0);
    check("t4_pc", instr_pc, 32'h28);
    step(1'b1, 1'b1, 32'h10);
    step(1'b1, 1'b0, 32'h0);
    check("t4_sticky", 32'(misalign_err), 32'h1);

    // Running off the end of the ROM halts fetch until a redirect.
    step(1'b1, 1'b1, 32'hFC);
    step(1'b1, 1'b0, 32'h0);
    check("t5_last", instr_pc, 32'hFC);
    step(1'b1, 1'b0, 32'h0);
    check("t5_oob", 32'(fetch_oob), 32'h1);
    check("t5_drained", 32'(instr_valid), 32'h0);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 32'h0);
    check("t5_addr", imem_addr, 32'h100);
    step(1'b1, 1'b1, 32'h0);
    check("t5_clear", 32'(fetch_oob), 32'h0);
    step(1'b1, 1'b0, 32'h0);
    check("t5_restart", instr_pc, 32'h0);

    // Randomized traffic with occasional redirects, some misaligned or beyond the ROM.
    for (int i = 0; i < 400; i++) begin
      rpc = 32'($urandom_range(0, 70)) << 2;
      if ($urandom_range(0, 7) == 0) rpc = rpc | 32'($urandom_range(1, 3));
      step(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 9) == 0), rpc);
    end

    // Asynchronous reset between edges while the queue is full.
    do_reset();
    step(1'b0, 1'b0, 32'h0);
    step(1'b0, 1'b0, 32'h0);
    check("t6_full", 32'(instr_valid), 32'h1);
    #2;
    reset = 1'b1;
    model_reset();
    #1;
    check("t6_async", 32'(instr_valid), 32'h0);
    check("t6_addr", imem_addr, 32'h0);
    #2;
    reset = 1'b0;
    step(1'b1, 1'b0, 32'h0);
    check("t6_pc", instr_pc, 32'h0);
    check("t6_instr", instr, 32'h0050_0113);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
